// File: rtl/uart_peripheral_pkg.sv
// uart_peripheral_pkg: shared definitions for the console UART peripheral.
// Register indices, the status word layout, the serial engine state encoding
// and the divisor sanitising helper shared by both engines.
package uart_peripheral_pkg;

  localparam int unsigned REG_IDX_W = 7;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DIV_W     = 16;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] UART_REG_DATA    = REG_IDX_W'(0);
  localparam logic [REG_IDX_W-1:0] UART_REG_STATUS  = REG_IDX_W'(1);
  localparam logic [REG_IDX_W-1:0] UART_REG_DIVISOR = REG_IDX_W'(2);

  // Serial engine states, shared by TX and RX.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Status register layout, bit 0 is tx_full.
  typedef struct packed {
    logic [9:0] rsvd;
    logic       tx_overflow;  // bit 5
    logic       rx_framing;   // bit 4
    logic       rx_overrun;   // bit 3
    logic       rx_valid;     // bit 2
    logic       tx_busy;      // bit 1
    logic       tx_full;      // bit 0
  } uart_status_t;

  // A programmed divisor of 0 behaves as 1 cycle per bit.
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/uart_peripheral_sync_fifo.sv
// uart_peripheral_sync_fifo: single-clock FIFO with first-word fall-through read.
// Ports: clk, reset (async, active-high), push/push_data, pop/pop_data,
//        full, empty. Push while full and pop while empty are ignored.
module uart_peripheral_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is evaluated before this edge's pop, so a simultaneous pop never frees room.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_peripheral.sv
// uart_peripheral: register-mapped 8N1 UART for the Lisp core console.
// Ports: clk, reset (async, active-high); register bus register_index/read/
//        write/write_value with combinational register_read_value;
//        uart_rx (async serial in), uart_tx (serial out, idles high).
// Registers: 0 data (write = TX push, read = RX byte), 1 status, 2 divisor.
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter int unsigned      TX_FIFO_DEPTH   = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIVISOR = 16'd100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] register_index,
  input  logic                 register_read,
  input  logic                 register_write,
  input  logic [DATA_W-1:0]    register_write_value,
  output logic [DATA_W-1:0]    register_read_value,
  input  logic                 uart_rx,
  output logic                 uart_tx
);

  logic [DIV_W-1:0]     div_q;
  logic [BYTE_W-1:0]    rx_data;
  logic                 rx_valid, rx_overrun, rx_framing, tx_overflow;
  logic                 rd_data, rd_status, wr_data, wr_div;
  logic                 tx_full, tx_empty, tx_pop, tx_busy;
  logic [BYTE_W-1:0]    fifo_data;
  uart_state_t          tx_state, rx_state;
  logic [DIV_W-1:0]     tx_cnt, tx_len, rx_cnt, rx_len, rx_half;
  logic [BYTE_W-1:0]    tx_shift, rx_shift;
  logic [BIT_IDX_W-1:0] tx_bit, rx_bit;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 rx_stop_sample, rx_good, rx_bad;
  uart_status_t         status;

  assign rd_data   = register_read  && (register_index == UART_REG_DATA);
  assign rd_status = register_read  && (register_index == UART_REG_STATUS);
  assign wr_data   = register_write && (register_index == UART_REG_DATA);
  assign wr_div    = register_write && (register_index == UART_REG_DIVISOR);

  uart_peripheral_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_data),
    .push_data (register_write_value[BYTE_W-1:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_data),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Pop from idle, or at the end of a stop bit to chain frames without a gap.
  assign tx_pop  = !tx_empty && ((tx_state == ST_IDLE) ||
                                 ((tx_state == ST_STOP) && (tx_cnt == tx_len)));
  assign tx_busy = !tx_empty || (tx_state != ST_IDLE);

  // TX engine; each bit lasts tx_len cycles, re-latched at every bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= DIV_W'(1);
      tx_len   <= DIV_W'(1);
      tx_shift <= '0;
      tx_bit   <= '0;
    end else if (tx_state == ST_IDLE) begin
      if (tx_pop) begin
        tx_state <= ST_START;
        uart_tx  <= 1'b0;
        tx_shift <= fifo_data;
        tx_cnt   <= DIV_W'(1);
        tx_len   <= eff_divisor(div_q);
      end
    end else if (tx_cnt != tx_len) begin
      tx_cnt <= tx_cnt + DIV_W'(1);
    end else begin
      tx_cnt <= DIV_W'(1);
      tx_len <= eff_divisor(div_q);
      case (tx_state)
        ST_START: begin
          tx_state <= ST_DATA;
          uart_tx  <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
          tx_bit   <= '0;
        end
        ST_DATA: begin
          if (tx_bit == BIT_IDX_W'(BYTE_W - 1)) begin
            tx_state <= ST_STOP;
            uart_tx  <= 1'b1;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
            tx_bit   <= tx_bit + BIT_IDX_W'(1);
          end
        end
        default: begin
          if (tx_pop) begin
            tx_state <= ST_START;
            uart_tx  <= 1'b0;
            tx_shift <= fifo_data;
          end else begin
            tx_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Start-bit re-check point: half a bit, but at least one cycle.
  assign rx_half        = (rx_len[DIV_W-1:1] == '0) ? DIV_W'(1) : {1'b0, rx_len[DIV_W-1:1]};
  assign rx_stop_sample = (rx_state == ST_STOP) && (rx_cnt == rx_len);
  assign rx_good        = rx_stop_sample && rx_sync;
  assign rx_bad         = rx_stop_sample && !rx_sync;

  // RX synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX engine; samples mid-bit after the start-bit re-check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= DIV_W'(1);
      rx_len   <= DIV_W'(1);
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (!rx_sync && rx_prev) begin
            rx_state <= ST_START;
            rx_cnt   <= DIV_W'(1);
            rx_len   <= eff_divisor(div_q);
          end
        end
        ST_START: begin
          if (rx_cnt != rx_half) begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end else if (rx_sync) begin
            rx_state <= ST_IDLE;
          end else begin
            rx_state <= ST_DATA;
            rx_cnt   <= DIV_W'(1);
            rx_len   <= eff_divisor(div_q);
            rx_bit   <= '0;
          end
        end
        ST_DATA: begin
          if (rx_cnt != rx_len) begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end else begin
            rx_shift <= {rx_sync, rx_shift[BYTE_W-1:1]};
            rx_cnt   <= DIV_W'(1);
            rx_len   <= eff_divisor(div_q);
            if (rx_bit == BIT_IDX_W'(BYTE_W - 1)) rx_state <= ST_STOP;
            else                                  rx_bit   <= rx_bit + BIT_IDX_W'(1);
          end
        end
        default: begin
          if (rx_cnt != rx_len) rx_cnt   <= rx_cnt + DIV_W'(1);
          else                  rx_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Divisor, received byte and status flags; set events beat read-clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= DEFAULT_DIVISOR;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      rx_framing  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_div) div_q <= register_write_value;

      if (rx_good) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end

      if (rx_good && rx_valid && !rd_data) rx_overrun  <= 1'b1;
      else if (rd_status)                  rx_overrun  <= 1'b0;

      if (rx_bad)                          rx_framing  <= 1'b1;
      else if (rd_status)                  rx_framing  <= 1'b0;

      if (wr_data && tx_full)              tx_overflow <= 1'b1;
      else if (rd_status)                  tx_overflow <= 1'b0;
    end
  end

  // Combinational read mux, zero when no read strobe.
  always_comb begin
    status             = '0;
    status.tx_full     = tx_full;
    status.tx_busy     = tx_busy;
    status.rx_valid    = rx_valid;
    status.rx_overrun  = rx_overrun;
    status.rx_framing  = rx_framing;
    status.tx_overflow = tx_overflow;
    register_read_value = '0;
    if (register_read) begin
      case (register_index)
        UART_REG_DATA:    register_read_value = {8'h00, rx_data};
        UART_REG_STATUS:  register_read_value = status;
        UART_REG_DIVISOR: register_read_value = div_q;
        default:          register_read_value = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_peripheral.sv
// tb_uart_peripheral: scoreboard bench for uart_peripheral.
// TX bytes are queued when written and popped by a serial frame monitor;
// RX bytes are queued when driven on the pin and popped on register-0 reads.
module tb_uart_peripheral;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  uart_peripheral #(.TX_FIFO_DEPTH(8), .DEFAULT_DIVISOR(16'd100)) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_rx              (uart_rx),
    .uart_tx              (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         bit_t = 100;
  bit         mon_en = 1'b1;
  bit         b2b_on = 1'b0;
  int         b2b_cnt = 0;
  int         prev_start = 0;
  bit         exp_overrun = 1'b0;
  bit         exp_framing = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected uart_tx samples of one frame, one entry per clock cycle.
  function automatic logic [63:0] frame_vec(input logic [7:0] b, input int d);
    logic [9:0]  f;
    logic [63:0] v;
    f = {1'b1, b, 1'b0};
    v = '0;
    for (int i = 0; i < 10 * d; i++) v[i] = f[i / d];
    return v;
  endfunction

  task automatic capture(input int n, output logic [63:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v[i] = uart_tx;
    end
  endtask

  task automatic reg_write(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx;
    register_write_value = val;
    register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic reg_read(input logic [6:0] idx, output logic [15:0] val);
    @(negedge clk);
    register_index = idx;
    register_read = 1'b1;
    #1 val = register_read_value;
    @(negedge clk);
    register_read = 1'b0;
  endtask

  task automatic write_burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      register_index = 7'd0;
      register_write_value = {8'h00, base + 8'(i)};
      register_write = 1'b1;
    end
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic wait_tx_drain(input int limit);
    int k;
    k = 0;
    while (tx_q.size() > 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("tx_drain_timeout", tx_q.size() == 0, 1);
    repeat (3) @(negedge clk);
  endtask

  // Drive one frame on the pin; the model tracks the unread byte and flags.
  task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (d - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    if (stop) begin
      if (rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        exp_overrun = 1'b1;
      end
      rx_q.push_back(b);
    end else begin
      exp_framing = 1'b1;
    end
  endtask

  task automatic check_rx_status(input string tag);
    logic [15:0] v;
    reg_read(7'd1, v);
    check(tag, v, {10'b0, 1'b0, exp_framing, exp_overrun, rx_q.size() > 0, 2'b00});
    exp_framing = 1'b0;
    exp_overrun = 1'b0;
  endtask

  task automatic rx_read_check(input string tag);
    logic [15:0] v;
    reg_read(7'd0, v);
    check("rx_sb_pending", rx_q.size() > 0, 1);
    if (rx_q.size() > 0) check(tag, v, {8'h00, rx_q.pop_front()});
  endtask

  // Serial monitor: decodes each frame at mid-bit and scores it.
  initial begin : tx_monitor
    logic [9:0] f;
    int         start;
    int         d;
    f = '0;
    forever begin
      @(negedge clk);
      if (mon_en && uart_tx === 1'b0) begin
        start = cyc;
        d = bit_t;
        for (int i = 0; i < 10 * d; i++) begin
          if (i > 0) @(negedge clk);
          if (i % d == d / 2) f[i / d] = uart_tx;
        end
        check("tx_start_bit", f[0], 0);
        check("tx_stop_bit", f[9], 1);
        check("tx_sb_pending", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) check("tx_byte", f[8:1], tx_q.pop_front());
        if (b2b_on) begin
          if (b2b_cnt > 0) check("tx_b2b_spacing", start - prev_start, 10 * d);
          b2b_cnt++;
        end
        prev_start = start;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] v;
    logic [63:0] vec;

    register_index = 7'd2;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_read_value_no_strobe", register_read_value, 0);
    reset = 1'b0;
    reg_read(7'd1, v); check("rst_status", v, 0);
    reg_read(7'd2, v); check("rst_divisor", v, 16'd100);
    reg_read(7'd0, v); check("rst_rx_data", v, 0);
    reg_read(7'd5, v); check("unmapped_read", v, 0);

    reg_write(7'd2, 16'd4);
    bit_t = 4;
    reg_read(7'd2, v); check("divisor_readback", v, 16'd4);

    // Single frame, exact cycle waveform.
    tx_q.push_back(8'h55);
    reg_write(7'd0, 16'h0055);
    capture(40, vec);
    check("tx_0x55_waveform", vec, frame_vec(8'h55, 4));
    reg_read(7'd1, v); check("tx_idle_after_frame", v, 0);

    // Overfill: first byte pops at once, next 8 fill the FIFO, the 10th drops.
    b2b_on = 1'b1;
    b2b_cnt = 0;
    for (int i = 0; i < 9; i++) tx_q.push_back(8'h10 + 8'(i));
    write_burst(10, 8'h10);
    reg_read(7'd1, v); check("status_overflow_set", v, 16'h0023);
    reg_read(7'd1, v); check("status_overflow_cleared", v, 16'h0003);
    wait_tx_drain(2000);
    b2b_on = 1'b0;
    check("tx_frame_count", b2b_cnt, 9);
    reg_read(7'd1, v); check("status_after_drain", v, 0);

    // Receive path.
    send_rx(8'hA3, 1'b1, 4);
    repeat (8) @(negedge clk);
    check_rx_status("rx_status_valid");
    rx_read_check("rx_data_a3");
    check_rx_status("rx_status_after_read");

    send_rx(8'h3C, 1'b1, 4);
    send_rx(8'hC5, 1'b1, 4);
    repeat (8) @(negedge clk);
    check_rx_status("rx_status_overrun");
    rx_read_check("rx_data_overwrite");
    check_rx_status("rx_status_overrun_cleared");

    send_rx(8'h5A, 1'b0, 4);
    repeat (8) @(negedge clk);
    check_rx_status("rx_status_framing");
    check_rx_status("rx_status_framing_cleared");

    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check_rx_status("rx_glitch_ignored");

    send_rx(8'h81, 1'b1, 4);
    repeat (8) @(negedge clk);
    rx_read_check("rx_data_after_glitch");

    // Divisor 0 acts as one cycle per bit.
    reg_write(7'd2, 16'd0);
    bit_t = 1;
    tx_q.push_back(8'h96);
    reg_write(7'd0, 16'h0096);
    capture(10, vec);
    check("tx_div0_waveform", vec, frame_vec(8'h96, 1));
    repeat (3) @(negedge clk);
    check("tx_div0_scored", tx_q.size(), 0);

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    reg_write(7'd0, 16'h00F0);
    repeat (3) @(negedge clk);
    check("pre_reset_tx_low", uart_tx, 0);
    register_index = 7'd1;
    register_read = 1'b1;
    #1 check("pre_reset_status_busy", register_read_value, 16'h0002);
    #1 reset = 1'b1;
    #1 check("reset_tx_high", uart_tx, 1);
    check("reset_status_zero", register_read_value, 0);
    register_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    reg_read(7'd2, v); check("post_reset_divisor", v, 16'd100);
    repeat (5) @(negedge clk);
    check("post_reset_tx_idle", uart_tx, 1);
    reg_read(7'd1, v); check("post_reset_status", v, 0);

    check("tx_sb_empty", tx_q.size(), 0);
    check("rx_sb_empty", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
